// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial operand sender.
package serial_tx_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_with_vld.sv
// Bit-serial adder fed LSB first. The sum is combinational from the current
// bits and the stored carry. The carry is cleared after the last bit, so
// consecutive operand pairs never leak a carry into each other.
module serial_adder_with_vld (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic a,
  input  logic b,
  input  logic last,
  output logic sum
);

  logic carry_q, carry_d;

  // carry update: advance on valid bits, restart after the final bit
  always_comb begin
    carry_d = carry_q;
    if (vld) carry_d = last ? 1'b0 : ((a & b) | (a & carry_q) | (b & carry_q));
  end

  // carry register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign sum = a ^ b ^ carry_q;

endmodule

// File: rtl/serial_operand_sender.sv
// Takes a parallel operand pair and streams it LSB first into a serial
// adder. The returned sum bits are collected into a parallel result, which
// is held until the downstream side takes it.
module serial_operand_sender
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             pause,
  output logic             out_vld,
  output logic             out_a,
  output logic             out_b,
  output logic             out_last,
  input  logic             sum_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state: accept in IDLE, leave SEND on the last bit, leave DONE on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_SEND;
      ST_SEND: if (out_last)  state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // outputs: serial stream only in SEND and only when not paused
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_vld   = (state_q == ST_SEND) && !pause;
    out_a     = out_vld & a_q[0];
    out_b     = out_vld & b_q[0];
    out_last  = out_vld && (cnt_q == CNT_LAST);
    res_valid = (state_q == ST_DONE);
    res_sum   = res_q;
  end

  // datapath: operands shift right so bit cnt is always at position 0
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (in_valid && in_ready) begin
      a_d   = in_a;
      b_d   = in_b;
      cnt_d = '0;
      res_d = '0;
    end else if (out_vld) begin
      a_d          = a_q >> 1;
      b_d          = b_q >> 1;
      res_d[cnt_q] = sum_in;
      cnt_d        = out_last ? '0 : cnt_q + CW'(1);
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_sender.sv
// Directed bench: sender wired back-to-back with the serial adder.
module tb_serial_operand_sender;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         pause;
  logic         out_vld, out_a, out_b, out_last;
  logic         sum_w;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         adder_rst;

  int tests = 0;
  int fails = 0;

  assign adder_rst = !rst_n;

  always #5 clk = ~clk;

  serial_operand_sender #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .pause(pause), .out_vld(out_vld),
    .out_a(out_a), .out_b(out_b), .out_last(out_last), .sum_in(sum_w),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum)
  );

  serial_adder_with_vld adder (
    .clk(clk), .rst(adder_rst), .vld(out_vld), .a(out_a), .b(out_b),
    .last(out_last), .sum(sum_w)
  );

  // Stimulus: present a pair (entered at posedge+1 while IDLE), run the
  // transfer with a per-SEND-cycle pause mask, return once res_valid is seen.
  // Leaves time at posedge+1 with the DUT in DONE.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [15:0] pmask,
                           output int ncyc, output int nvld,
                           output int last_at, output int bad);
    ncyc = -1; nvld = 0; last_at = -1; bad = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    #1;
    if (in_ready !== 1'b1) bad++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b;
    for (int k = 0; k < 40; k++) begin
      pause = pmask[k % 16];
      #1;
      if (out_vld !== !pause) bad++;
      if (out_last && !out_vld) bad++;
      if (pause && (out_a || out_b || out_last)) bad++;
      if (res_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      if (out_vld) nvld++;
      if (out_last) last_at = k;
      @(posedge clk); #1;
      if (res_valid) begin
        ncyc = k + 1;
        break;
      end
    end
    pause = 1'b0;
  endtask

  // Stimulus: complete the result handshake, return at posedge+1 in IDLE.
  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    pause = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hs ready=%b valid=%b want 1 0", in_ready, res_valid);
    end
    tests++;
    if ({out_vld, out_a, out_b, out_last} !== 4'b0) begin
      fails++; $display("FAIL reset_out out=%b want 0000", {out_vld, out_a, out_b, out_last});
    end
    tests++;
    if (res_sum !== 8'h00) begin
      fails++; $display("FAIL reset_sum got %h want 00", res_sum);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int nc, nv, la, bd;
    send_pair(8'h35, 8'h4A, 16'h0000, nc, nv, la, bd);
    tests++;
    if (res_sum !== 8'h7F) begin
      fails++; $display("FAIL basic_sum got %h want 7f", res_sum);
    end
    tests++;
    if (nc !== 8 || nv !== 8) begin
      fails++; $display("FAIL basic_latency cycles=%0d vld=%0d want 8 8", nc, nv);
    end
    tests++;
    if (la !== 7 || bd !== 0) begin
      fails++; $display("FAIL basic_stream last_at=%0d bad=%0d want 7 0", la, bd);
    end
    tests++;
    if ({out_vld, out_a, out_b, out_last} !== 4'b0) begin
      fails++; $display("FAIL done_out out=%b want 0000", {out_vld, out_a, out_b, out_last});
    end
    consume();
    tests++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      fails++; $display("FAIL basic_idle ready=%b valid=%b want 1 0", in_ready, res_valid);
    end
  endtask

  task automatic test_carry();
    int nc, nv, la, bd;
    send_pair(8'hFF, 8'h01, 16'h0000, nc, nv, la, bd);
    tests++;
    if (res_sum !== 8'h00 || bd !== 0) begin
      fails++; $display("FAIL carry_wrap got %h bad=%0d want 00 0", res_sum, bd);
    end
    consume();
    send_pair(8'h01, 8'h01, 16'h0000, nc, nv, la, bd);
    tests++;
    if (res_sum !== 8'h02 || nc !== 8) begin
      fails++; $display("FAIL carry_leak got %h cycles=%0d want 02 8", res_sum, nc);
    end
    consume();
  endtask

  task automatic test_pause();
    int nc, nv, la, bd;
    send_pair(8'h12, 8'h34, 16'h0088, nc, nv, la, bd);
    tests++;
    if (nc !== 10 || nv !== 8) begin
      fails++; $display("FAIL pause_len cycles=%0d vld=%0d want 10 8", nc, nv);
    end
    tests++;
    if (la !== 9 || bd !== 0) begin
      fails++; $display("FAIL pause_stream last_at=%0d bad=%0d want 9 0", la, bd);
    end
    tests++;
    if (res_sum !== 8'h46) begin
      fails++; $display("FAIL pause_sum got %h want 46", res_sum);
    end
    consume();
  endtask

  task automatic test_done_hold();
    int nc, nv, la, bd;
    int hold_bad;
    hold_bad = 0;
    send_pair(8'h9C, 8'h21, 16'h0000, nc, nv, la, bd);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); in_a = 8'h77; in_b = 8'h11;
      #1;
      if (res_sum !== 8'hBD || in_ready !== 1'b0 || res_valid !== 1'b1) hold_bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (hold_bad !== 0) begin
      fails++; $display("FAIL done_hold bad_cycles=%0d want 0 (sum %h want bd)", hold_bad, res_sum);
    end
    consume();
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_vld !== 1'b0) begin
      fails++; $display("FAIL done_ignore ready=%b vld=%b want 1 0", in_ready, out_vld);
    end
  endtask

  task automatic test_reset_mid();
    int nc, nv, la, bd;
    int seen_valid;
    seen_valid = 0;
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_vld !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL rst_async ready=%b vld=%b res_valid=%b want 1 0 0", in_ready, out_vld, res_valid);
    end
    tests++;
    if (res_sum !== 8'h00) begin
      fails++; $display("FAIL rst_sum got %h want 00", res_sum);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen_valid++;
    end
    rst_n = 1'b1;
    send_pair(8'h0F, 8'h01, 16'h0000, nc, nv, la, bd);
    tests++;
    if (seen_valid !== 0 || bd !== 0) begin
      fails++; $display("FAIL rst_abandon valid_seen=%0d bad=%0d want 0 0", seen_valid, bd);
    end
    tests++;
    if (res_sum !== 8'h10 || nc !== 8) begin
      fails++; $display("FAIL rst_next got %h cycles=%0d want 10 8", res_sum, nc);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic [W-1:0] ps [4];
    int acc [4];
    int aidx, ridx, cyc, bad_gap;
    pa = '{8'hFF, 8'h80, 8'h5A, 8'h3C};
    pb = '{8'hFF, 8'h80, 8'hA5, 8'h0B};
    ps = '{8'hFE, 8'h00, 8'hFF, 8'h47};
    aidx = 0; ridx = 0; cyc = 0; bad_gap = 0;
    res_ready = 1'b1;
    while (ridx < 4 && cyc < 200) begin
      in_valid = (aidx < 4);
      in_a = pa[aidx % 4]; in_b = pb[aidx % 4];
      #1;
      if (res_valid) begin
        tests++;
        if (res_sum !== ps[ridx]) begin
          fails++; $display("FAIL b2b_sum[%0d] got %h want %h", ridx, res_sum, ps[ridx]);
        end
        ridx++;
      end
      if (in_ready && aidx < 4) begin
        acc[aidx] = cyc;
        aidx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; res_ready = 1'b0;
    for (int i = 1; i < aidx; i++) if (acc[i] - acc[i-1] !== W + 2) bad_gap++;
    tests++;
    if (ridx !== 4 || aidx !== 4 || bad_gap !== 0) begin
      fails++; $display("FAIL b2b_rate results=%0d accepts=%0d bad_gaps=%0d want 4 4 0", ridx, aidx, bad_gap);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_carry();
    test_pause();
    test_done_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
